bp_fe_queue_fifo: RTL

Checkpointed circular buffer between the front end's fetch-queue output and the back end's issue stage. It accepts fetch-queue entries with a valid/ready handshake and presents them in order to the back end. The back end reads speculatively and commits entries only once they retire. A roll-back rewinds reading to the oldest uncommitted entry; a clear discards all unread entries on a redirect.

---
 rtl/bp_fe_queue_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/bp_fe_queue_fifo.sv
// bp_fe_queue_fifo
//
// Checkpointed circular buffer between the front-end fetch queue and the
// back-end issue stage. Entries are written in order with a valid/ready
// handshake. The back end reads them speculatively through rptr and commits
// them later through cptr. Only a commit frees a slot, so an entry stays in
// the buffer until it retires and can be replayed by a roll-back.
//
// Ports
//   clk_i      sole clock, all state updates on the rising edge
//   reset_n_i  asynchronous active-low reset
//   data_i     entry from the front end
//   v_i        data_i valid
//   ready_o    space available (registered pointers only)
//   data_o     entry at the read pointer (meaningless when v_o = 0)
//   v_o        an unread entry is available
//   yumi_i     consume data_o, advancing the read pointer
//   deq_i      commit the oldest read-but-uncommitted entry
//   roll_i     rewind the read pointer to the commit pointer
//   clr_i      discard all unread entries
//   count_o    occupied slots, enq_ptr - cptr
module bp_fe_queue_fifo #(
    parameter  int els_p   = 8,
    parameter  int width_p = 128,
    localparam int ptr_w   = $clog2(els_p) + 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i,
    input  logic               deq_i,
    input  logic               roll_i,
    input  logic               clr_i,
    output logic [ptr_w-1:0]   count_o
);

    localparam int idx_w = ptr_w - 1;

    // Storage is deliberately not reset; validity is carried by the pointers.
    logic [width_p-1:0] mem [els_p];

    // Each pointer carries one extra wrap bit above the slot index so that
    // full and empty can be told apart when the index bits match.
    logic [ptr_w-1:0] enq_ptr, rptr, cptr;
    logic [ptr_w-1:0] enq_ptr_n, rptr_n, cptr_n;

    logic full;
    logic wr_en;
    logic rd_en;
    logic cm_en;

    // Flags depend on registered pointers only.
    assign full    = (enq_ptr[idx_w-1:0] == cptr[idx_w-1:0])
                  && (enq_ptr[ptr_w-1]   != cptr[ptr_w-1]);
    assign ready_o = ~full;
    assign v_o     = (rptr != enq_ptr);
    assign count_o = enq_ptr - cptr;

    // A clear in the same cycle always discards the incoming entry.
    assign wr_en = v_i & ready_o & ~clr_i;
    // Reads only count when something is actually there to read.
    assign rd_en = yumi_i & v_o;
    // A commit can never overtake the speculative read pointer.
    assign cm_en = deq_i & (cptr != rptr);

    always_comb begin
        cptr_n    = cptr;
        rptr_n    = rptr;
        enq_ptr_n = enq_ptr;

        if (cm_en) begin
            cptr_n = cptr + ptr_w'(1);
        end

        // Roll-back targets the post-commit pointer so a same-cycle deq is
        // never lost.
        if (roll_i && clr_i) begin
            // Drop every uncommitted entry, read or not.
            rptr_n    = cptr_n;
            enq_ptr_n = cptr_n;
        end else if (clr_i) begin
            // Drop only the unread entries; read-but-uncommitted ones stay
            // so they can still be committed.
            enq_ptr_n = rptr;
        end else if (roll_i) begin
            rptr_n = cptr_n;
            if (wr_en) begin
                enq_ptr_n = enq_ptr + ptr_w'(1);
            end
        end else begin
            if (rd_en) begin
                rptr_n = rptr + ptr_w'(1);
            end
            if (wr_en) begin
                enq_ptr_n = enq_ptr + ptr_w'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            enq_ptr <= '0;
            rptr    <= '0;
            cptr    <= '0;
        end else begin
            enq_ptr <= enq_ptr_n;
            rptr    <= rptr_n;
            cptr    <= cptr_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[enq_ptr[idx_w-1:0]] <= data_i;
        end
    end

    // No bypass: a freshly written entry shows up one cycle later.
    assign data_o = mem[rptr[idx_w-1:0]];

endmodule
